// File: rtl/plru_tree_array_if.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree_array_if
// Description : Controller-side bundle for the tree pseudo-LRU state array.
//               master = cache controller, slave = plru_tree_array.
//               Flush : flush_req -> busy, flush_done
//               Touch : touch_valid, touch_index, touch_way
//               Query : query_valid, query_index, valid_mask, lock_mask
//                       -> victim_valid, victim_way, all_locked
// Revision    : 1.0 - initial release
// ============================================================================
interface plru_tree_array_if #(
  parameter int S_INDEX = 3,
  parameter int S_WAY   = 3
);
  localparam int WAYS = 2 ** S_WAY;

  logic               flush_req;
  logic               busy;
  logic               flush_done;
  logic               touch_valid;
  logic [S_INDEX-1:0] touch_index;
  logic [S_WAY-1:0]   touch_way;
  logic               query_valid;
  logic [S_INDEX-1:0] query_index;
  logic [WAYS-1:0]    valid_mask;
  logic [WAYS-1:0]    lock_mask;
  logic               victim_valid;
  logic [S_WAY-1:0]   victim_way;
  logic               all_locked;

  modport master (
    output flush_req, touch_valid, touch_index, touch_way,
           query_valid, query_index, valid_mask, lock_mask,
    input  busy, flush_done, victim_valid, victim_way, all_locked
  );

  modport slave (
    input  flush_req, touch_valid, touch_index, touch_way,
           query_valid, query_index, valid_mask, lock_mask,
    output busy, flush_done, victim_valid, victim_way, all_locked
  );
endinterface
`default_nettype wire

// File: rtl/plru_tree_array.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree_array
// Description : Per-set tree pseudo-LRU replacement state for an N-way
//               set-associative cache. Heap-ordered tree per set; node bit 1
//               steers the victim search into the lower half. Supports lock
//               masks, invalid-way-first choice, same-cycle touch forwarding
//               and a one-set-per-cycle flush sweep.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - plru_tree_array_if.slave (flush / touch / query)
// Revision    : 1.0 - initial release
// ============================================================================
module plru_tree_array #(
  parameter int S_INDEX = 3,
  parameter int S_WAY   = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  plru_tree_array_if.slave bus
);
  localparam int SETS  = 2 ** S_INDEX;
  localparam int WAYS  = 2 ** S_WAY;
  localparam int NODES = WAYS - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [S_INDEX:0] flush_cnt;
  logic             flush_last;
  logic             flush_done;
  logic             busy;
  logic             flush_we;
  logic             touch_en;
  logic             query_en;

  logic [NODES-1:0] tree_mem [SETS];
  logic [NODES-1:0] touch_old;
  logic [NODES-1:0] touch_new;
  logic [NODES-1:0] query_tree;

  logic             inv_found;
  logic [S_WAY-1:0] inv_way;
  logic [S_WAY-1:0] tree_way;
  logic             sel_all_locked;
  logic [S_WAY-1:0] sel_way;

  logic             victim_valid;
  logic [S_WAY-1:0] victim_way;
  logic             all_locked;

  // --------------------------------------------------------------------------
  // Flush FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == ST_FLUSH) && flush_last;
      if (state == ST_FLUSH) begin
        flush_cnt <= flush_last ? '0 : flush_cnt + 1'b1;
      end
    end
  end

  // Flush FSM: next-state logic
  always_comb begin
    state_nxt  = state;
    flush_last = (flush_cnt == (S_INDEX + 1)'(SETS - 1));
    case (state)
      ST_IDLE:  if (bus.flush_req) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_last)    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Flush FSM: outputs. A touch coinciding with flush_req is discarded; a
  // query in that cycle is still served from the pre-flush tree.
  always_comb begin
    busy     = (state == ST_FLUSH);
    flush_we = (state == ST_FLUSH);
    touch_en = (state == ST_IDLE) && bus.touch_valid && !bus.flush_req;
    query_en = (state == ST_IDLE) && bus.query_valid;
  end

  // --------------------------------------------------------------------------
  // Touch: every node on the way's path points away from it. The node at
  // level l, position j lies on the path when the top l way bits equal j.
  // --------------------------------------------------------------------------
  assign touch_old = tree_mem[bus.touch_index];

  for (genvar l = 0; l < S_WAY; l++) begin : g_touch_lvl
    for (genvar j = 0; j < 2 ** l; j++) begin : g_touch_node
      localparam int K = 2 ** l - 1 + j;
      if (l == 0) begin : g_root
        assign touch_new[K] = bus.touch_way[S_WAY-1];
      end else begin : g_inner
        assign touch_new[K] = (32'(bus.touch_way[S_WAY-1 -: l]) == j)
                              ? bus.touch_way[S_WAY-1-l] : touch_old[K];
      end
    end
  end

  // Same-cycle forwarding of an accepted touch into the query.
  assign query_tree = (touch_en && (bus.touch_index == bus.query_index))
                      ? touch_new : tree_mem[bus.query_index];

  // --------------------------------------------------------------------------
  // Tree walk. Each level carries the way prefix chosen so far; the child
  // lock flags say whether a whole subtree is locked, in which case the walk
  // is forced to the sibling subtree.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < S_WAY; l++) begin : g_walk
    localparam int SPAN = 2 ** (S_WAY - l - 1);
    logic [2**l-1:0]     lvl_nodes;
    logic [2**(l+1)-1:0] child_lock;
    logic                node_bit;
    logic                go_lower;
    logic [l:0]          pfx;

    assign lvl_nodes = query_tree[2**l-1 +: 2**l];

    for (genvar j = 0; j < 2 ** (l + 1); j++) begin : g_child
      assign child_lock[j] = &bus.lock_mask[j*SPAN +: SPAN];
    end

    if (l == 0) begin : g_root
      assign node_bit = lvl_nodes[0];
      assign go_lower = node_bit ? !child_lock[0] : child_lock[1];
      assign pfx      = !go_lower;
    end else begin : g_inner
      assign node_bit = lvl_nodes[g_walk[l-1].pfx];
      assign go_lower = node_bit ? !child_lock[{g_walk[l-1].pfx, 1'b0}]
                                 :  child_lock[{g_walk[l-1].pfx, 1'b1}];
      assign pfx      = {g_walk[l-1].pfx, !go_lower};
    end
  end

  assign tree_way = g_walk[S_WAY-1].pfx;

  // Lowest-index unlocked invalid way (scan downward so the lowest wins).
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!bus.valid_mask[w] && !bus.lock_mask[w]) begin
        inv_found = 1'b1;
        inv_way   = S_WAY'(w);
      end
    end
  end

  always_comb begin
    sel_all_locked = &bus.lock_mask;
    if (sel_all_locked) sel_way = '0;
    else if (inv_found) sel_way = inv_way;
    else                sel_way = tree_way;
  end

  // --------------------------------------------------------------------------
  // Tree storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) tree_mem[s] <= '1;
    end else if (flush_we) begin
      tree_mem[flush_cnt[S_INDEX-1:0]] <= '1;
    end else if (touch_en) begin
      tree_mem[bus.touch_index] <= touch_new;
    end
  end

  // Registered victim result, held until the next accepted query.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
      all_locked   <= 1'b0;
    end else begin
      victim_valid <= query_en;
      if (query_en) begin
        victim_way <= sel_way;
        all_locked <= sel_all_locked;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.flush_done   = flush_done;
  assign bus.victim_valid = victim_valid;
  assign bus.victim_way   = victim_way;
  assign bus.all_locked   = all_locked;
endmodule
`default_nettype wire
